// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Boot/test-time program loader that sits in front of the instruction-memory
// write port. RV32I instruction fields arrive as bundles over valid/ready. Each
// bundle is packed into a 32-bit instruction word in a single encode stage.
// The words are then written to consecutive imem word addresses, starting at
// base_addr.
//
// Type codes: R=000 I=001 S=010 B=011 U=100 J=101. Codes 110/111 are illegal:
// the loader writes a NOP (0x00000013) in their place and raises err.
//
// Optional feature (macro IMM_RANGE_CHECK_EN):
//   When the macro is defined, immediates that do not fit their encoding are
//   flagged with err. Such a bundle is consumed but not written. When the macro
//   is undefined, out-of-range bits are silently truncated.
//
// Parameters:
//   ADDR_WIDTH  imem word-address width
//   DEPTH       maximum number of words written per load session
//
// Ports:
//   clk, rst_n         clock (rising edge); synchronous active-low reset
//   start, base_addr   begin a session at base_addr (sampled only in IDLE)
//   in_valid/in_ready  field bundle handshake; in_last marks the final bundle
//   in_type .. in_imm  instruction fields
//   imem_we/imem_ready imem write handshake; imem_addr/imem_wdata are the
//                      write address and data
//   count              words written this session
//   done               one-cycle pulse at session end
//   full               sticky: session ended by the DEPTH limit
//   err                sticky: illegal type (or immediate range violation)
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            in_type,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  imem_we,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  full,
  output logic                  err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [31:0]         NOP_C   = 32'h0000_0013;

  // Shift-immediate forms (slli/srli/srai) carry funct7 above a 5-bit shamt.
  function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
    return (op == 7'b0010011) && ((f3 == 3'b001) || (f3 == 3'b101));
  endfunction

  // Returns {illegal_type, word}.
  function automatic logic [32:0] encode_word(
    input logic [2:0]  typ,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        bad;
    w   = NOP_C;
    bad = 1'b0;
    case (typ)
      3'b000: w = {f7, rs2, rs1, f3, rd, op};
      3'b001: begin
        if (is_shift(op, f3)) begin
          w = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          w = {imm[11:0], rs1, f3, rd, op};
        end
      end
      3'b010: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'b011: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'b100: w = {imm[31:12], rd, op};
      3'b101: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: begin
        w   = NOP_C;
        bad = 1'b1;
      end
    endcase
    return {bad, w};
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  // True when every bit of the upper slice equals the sign, i.e. the value fits.
  function automatic logic sign_ok(input logic [31:0] v, input int msb_keep);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (b >= msb_keep) begin
        all_one  = all_one & v[b];
        all_zero = all_zero & ~v[b];
      end else begin
        all_one  = all_one;
        all_zero = all_zero;
      end
    end
    return all_one | all_zero;
  endfunction

  function automatic logic imm_bad(input logic [2:0] typ, input logic [6:0] op,
                                   input logic [2:0] f3, input logic [31:0] imm);
    logic bad;
    bad = 1'b0;
    case (typ)
      3'b001: begin
        if (is_shift(op, f3)) begin
          bad = (imm[31:5] != 27'd0);
        end else begin
          bad = !sign_ok(imm, 11);
        end
      end
      3'b010: bad = !sign_ok(imm, 11);
      3'b011: bad = !sign_ok(imm, 12) || imm[0];
      3'b101: bad = !sign_ok(imm, 20) || imm[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  stage_valid_r;
  logic [ADDR_WIDTH-1:0] imem_addr_r;
  logic [31:0]           imem_wdata_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  done_r;
  logic                  full_r;
  logic                  err_r;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  write_s;
  logic                  load_s;
  logic                  range_err_s;
  logic                  illegal_s;
  logic [31:0]           word_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  stage_nxt_s;
  logic                  depth_hit_s;
  logic                  full_set_s;

  assign {illegal_s, word_s} = encode_word(in_type, in_opcode, in_funct3, in_funct7,
                                           in_rd, in_rs1, in_rs2, in_imm);

`ifdef IMM_RANGE_CHECK_EN
  assign range_err_s = imm_bad(in_type, in_opcode, in_funct3, in_imm);
`else
  assign range_err_s = 1'b0;
`endif

  // The stage may refill in the same cycle it drains, so readiness depends on imem_ready.
  assign in_ready_s = (state_r == ST_RUN) && (!stage_valid_r || imem_ready) &&
                      ((count_r + (ADDR_WIDTH+1)'(stage_valid_r)) < DEPTH_C);
  assign accept_s   = in_valid && in_ready_s;
  assign write_s    = stage_valid_r && imem_ready;
  assign load_s     = accept_s && !range_err_s;

  // Session progress as it will stand after this edge: words written plus the one pending.
  assign count_nxt_s = count_r + (ADDR_WIDTH+1)'(write_s);
  assign stage_nxt_s = load_s || (stage_valid_r && !write_s);
  assign depth_hit_s = ((count_nxt_s + (ADDR_WIDTH+1)'(stage_nxt_s)) == DEPTH_C);

  // Next-state and DEPTH-limit decision for the session FSM.
  always_comb begin
    state_nxt_s = state_r;
    full_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && in_last) begin
          state_nxt_s = ST_DRAIN;
        end else if (depth_hit_s) begin
          state_nxt_s = ST_DRAIN;
          full_set_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!stage_nxt_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Session state, encode stage, write address/count and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      stage_valid_r <= 1'b0;
      imem_addr_r   <= '0;
      imem_wdata_r  <= 32'h0000_0000;
      count_r       <= '0;
      done_r        <= 1'b0;
      full_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);

      if (load_s) begin
        stage_valid_r <= 1'b1;
        imem_wdata_r  <= word_s;
      end else if (write_s) begin
        stage_valid_r <= 1'b0;
      end

      if ((state_r == ST_IDLE) && start) begin
        imem_addr_r <= base_addr;
        count_r     <= '0;
        full_r      <= 1'b0;
        err_r       <= 1'b0;
      end else begin
        if (write_s) begin
          imem_addr_r <= imem_addr_r + ADDR_WIDTH'(1);
          count_r     <= count_nxt_s;
        end
        if (full_set_s) begin
          full_r <= 1'b1;
        end
        if (accept_s && (illegal_s || range_err_s)) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign imem_we    = stage_valid_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign count      = count_r;
  assign done       = done_r;
  assign full       = full_r;
  assign err        = err_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed, table-driven bench for instr_encoder_loader (DEPTH=4 so the
// session limit is easy to reach). A negedge monitor logs every imem write
// and every done cycle; the tests compare the log against hand-computed words.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [2:0]    in_type = 3'd0;
  logic [6:0]    in_opcode = 7'd0;
  logic [2:0]    in_funct3 = 3'd0;
  logic [6:0]    in_funct7 = 7'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_rs1 = 5'd0;
  logic [4:0]    in_rs2 = 5'd0;
  logic [31:0]   in_imm = 32'd0;
  logic          imem_we;
  logic          imem_ready = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          full;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  vec_t vecs[11];

  instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
    .done(done), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (imem_we && imem_ready) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [31:0] w, input logic e);
    vec_t v;
    v.typ = t; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp_word = w; v.exp_err = e;
    return v;
  endfunction

  task automatic start_session(input logic [AW-1:0] base);
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic last, input int budget, output logic accepted);
    in_type = v.typ; in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_last = last;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < budget && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input int snap);
    for (int k = 0; k < 60 && done_cnt <= snap; k++) begin
      @(posedge clk); #1;
    end
    check("done_pulse", 32'(done_cnt - snap), 32'd1);
  endtask

  initial begin
    logic acc;
    int   snap;
    int   dsnap;
    vec_t v;
    logic [AW-1:0] addr_h;
    logic [31:0]   data_h;

    vecs[0]  = mk(3'b001, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0050_0093, 1'b0);
    vecs[1]  = mk(3'b000, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h0020_81B3, 1'b0);
    vecs[2]  = mk(3'b000, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,        32'h4020_81B3, 1'b0);
    vecs[3]  = mk(3'b010, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_A423, 1'b0);
    vecs[4]  = mk(3'b011, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_8463, 1'b0);
    vecs[5]  = mk(3'b101, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h800,      32'h0010_00EF, 1'b0);
    vecs[6]  = mk(3'b100, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vecs[7]  = mk(3'b001, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3,        32'h4031_5093, 1'b0);
    vecs[8]  = mk(3'b001, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_8093, 1'b0);
    vecs[9]  = mk(3'b111, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h0000_0013, 1'b1);
    vecs[10] = mk(3'b110, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4,        32'h0000_0013, 1'b1);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {29'd0, done, full, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One single-bundle session per table entry.
    for (int i = 0; i < 11; i++) begin
      snap = wr_addr_q.size();
      dsnap = done_cnt;
      start_session(AW'(16 * i + 1));
      send(vecs[i], 1'b1, 20, acc);
      check("vec_accept", 32'(acc), 32'd1);
      wait_done(dsnap);
      check("vec_nwrites", 32'(wr_addr_q.size() - snap), 32'd1);
      if (wr_addr_q.size() > snap) begin
        check("vec_addr", 32'(wr_addr_q[snap]), 32'(16 * i + 1));
        check("vec_word", wr_data_q[snap], vecs[i].exp_word);
      end
      check("vec_count", 32'(count), 32'd1);
      check("vec_err", 32'(err), 32'(vecs[i].exp_err));
      check("vec_full", 32'(full), 32'd0);
      @(posedge clk); #1;
    end

    // Three-cycle imem stall in the middle of a three-word stream.
    snap = wr_addr_q.size();
    dsnap = done_cnt;
    start_session(AW'(100));
    fork
      begin
        logic a;
        send(vecs[1], 1'b0, 20, a); check("bp_acc0", 32'(a), 32'd1);
        send(vecs[2], 1'b0, 20, a); check("bp_acc1", 32'(a), 32'd1);
        send(vecs[3], 1'b1, 20, a); check("bp_acc2", 32'(a), 32'd1);
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        imem_ready = 1'b0;
        @(negedge clk);
        addr_h = imem_addr;
        data_h = imem_wdata;
        check("bp_held_addr", 32'(addr_h), 32'd101);
        check("bp_held_word", data_h, 32'h4020_81B3);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("bp_we", 32'(imem_we), 32'd1);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_addr_stable", 32'(imem_addr), 32'(addr_h));
          check("bp_data_stable", imem_wdata, data_h);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
      end
    join
    wait_done(dsnap);
    check("bp_nwrites", 32'(wr_addr_q.size() - snap), 32'd3);
    if (wr_addr_q.size() >= snap + 3) begin
      for (int k = 0; k < 3; k++) begin
        check("bp_addr", 32'(wr_addr_q[snap + k]), 32'(100 + k));
        check("bp_word", wr_data_q[snap + k], vecs[k + 1].exp_word);
      end
    end
    check("bp_count", 32'(count), 32'd3);
    @(posedge clk); #1;

    // DEPTH limit: five bundles, no in_last; the fifth is never accepted.
    snap = wr_addr_q.size();
    dsnap = done_cnt;
    start_session(AW'(40));
    for (int k = 0; k < 5; k++) begin
      v = vecs[0];
      v.imm = 32'(k);
      send(v, 1'b0, (k < 4) ? 20 : 8, acc);
      check("depth_accept", 32'(acc), (k < 4) ? 32'd1 : 32'd0);
    end
    wait_done(dsnap);
    check("depth_nwrites", 32'(wr_addr_q.size() - snap), 32'd4);
    if (wr_addr_q.size() >= snap + 4) begin
      for (int k = 0; k < 4; k++) begin
        check("depth_addr", 32'(wr_addr_q[snap + k]), 32'(40 + k));
        check("depth_word", wr_data_q[snap + k], 32'h0000_0093 | (32'(k) << 20));
      end
    end
    check("depth_full", 32'(full), 32'd1);
    check("depth_count", 32'(count), 32'd4);
    check("depth_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Address wraps from the top of imem to 0.
    snap = wr_addr_q.size();
    dsnap = done_cnt;
    start_session(AW'(1023));
    send(vecs[1], 1'b0, 20, acc);
    send(vecs[2], 1'b1, 20, acc);
    wait_done(dsnap);
    check("wrap_nwrites", 32'(wr_addr_q.size() - snap), 32'd2);
    if (wr_addr_q.size() >= snap + 2) begin
      check("wrap_addr0", 32'(wr_addr_q[snap]), 32'd1023);
      check("wrap_addr1", 32'(wr_addr_q[snap + 1]), 32'd0);
      check("wrap_word1", wr_data_q[snap + 1], 32'h4020_81B3);
    end
    check("wrap_count", 32'(count), 32'd2);
    @(posedge clk); #1;

    // B immediate 7 is odd: dropped with the range check, truncated without it.
    snap = wr_addr_q.size();
    dsnap = done_cnt;
    start_session(AW'(200));
    v = vecs[4];
    v.imm = 32'd7;
    send(v, 1'b1, 20, acc);
    check("range_accept", 32'(acc), 32'd1);
    wait_done(dsnap);
`ifdef IMM_RANGE_CHECK_EN
    check("range_nwrites", 32'(wr_addr_q.size() - snap), 32'd0);
    check("range_err", 32'(err), 32'd1);
    check("range_count", 32'(count), 32'd0);
`else
    check("range_nwrites", 32'(wr_addr_q.size() - snap), 32'd1);
    if (wr_addr_q.size() > snap) check("range_word", wr_data_q[snap], 32'h0020_8363);
    check("range_err", 32'(err), 32'd0);
    check("range_count", 32'(count), 32'd1);
`endif
    @(posedge clk); #1;

    // Reset while a word is pending under backpressure: the word is discarded.
    snap = wr_addr_q.size();
    imem_ready = 1'b0;
    start_session(AW'(300));
    send(vecs[0], 1'b0, 20, acc);
    @(negedge clk);
    check("mrst_pending_we", 32'(imem_we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_imem_we", 32'(imem_we), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_addr", 32'(imem_addr), 32'd0);
    check("mrst_wdata", imem_wdata, 32'd0);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_flags", {29'd0, done, full, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mrst_no_write", 32'(wr_addr_q.size() - snap), 32'd0);
    check("mrst_idle_we", 32'(imem_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
